// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants and FSM state type for the linear scaler controller
package scaler_pkg;
  localparam int STEP        = 4096;
  localparam int FRAC_W      = $clog2(STEP);
  localparam int STEP_WIDTH  = 16;
  localparam int PIXEL_WIDTH = 8;
  localparam int LINE_W      = 13;
  localparam int POS_W       = LINE_W + FRAC_W;
  localparam int DX_W        = FRAC_W - 1;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} scaler_ctrl_state_t;
endpackage

// File: rtl/linear_scaler_ctrl_if.sv
// linear_scaler_ctrl_if: line control, pixel input, coefficient index and pixel-pair output bundle
interface linear_scaler_ctrl_if;
  import scaler_pkg::*;
  logic                   start;
  logic [STEP_WIDTH-1:0]  scale_step;
  logic [LINE_W-1:0]      in_width;
  logic [LINE_W-1:0]      out_width;
  logic                   busy;
  logic [PIXEL_WIDTH-1:0] di_pix;
  logic                   di_valid;
  logic                   di_ready;
  logic                   dx_en;
  logic [DX_W-1:0]        dx;
  logic [PIXEL_WIDTH-1:0] do_pix0;
  logic [PIXEL_WIDTH-1:0] do_pix1;
  logic                   do_valid;
  logic                   do_ready;
  logic                   do_eol;
  modport slave (
    input  start, scale_step, in_width, out_width, di_pix, di_valid, do_ready,
    output busy, di_ready, dx_en, dx, do_pix0, do_pix1, do_valid, do_eol
  );
  modport master (
    output start, scale_step, in_width, out_width, di_pix, di_valid, do_ready,
    input  busy, di_ready, dx_en, dx, do_pix0, do_pix1, do_valid, do_eol
  );
endinterface

// File: rtl/scaler_pos_acc.sv
// scaler_pos_acc: fixed-point output position; LINEAR_SCALER_CTRL_CENTER_EN selects centre-aligned start
module scaler_pos_acc
  import scaler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_i,
  input  logic                  adv_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  output logic [LINE_W-1:0]     pos_int_o,
  output logic [DX_W-1:0]       pos_frac_o
);
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [POS_W-1:0]      pos_q, pos_d, init_pos;
`ifdef LINEAR_SCALER_CTRL_CENTER_EN
  // (step - STEP)/2 taken signed: upscale steps would go negative, so they clamp to 0
  assign init_pos = (step_i > STEP_WIDTH'(STEP)) ? POS_W'((step_i - STEP_WIDTH'(STEP)) >> 1) : '0;
`else
  assign init_pos = '0;
`endif
  assign step_d     = init_i ? step_i : step_q;
  assign pos_d      = init_i ? init_pos : adv_i ? pos_q + POS_W'(step_q) : pos_q;
  assign pos_int_o  = pos_q[POS_W-1:FRAC_W];
  assign pos_frac_o = pos_q[FRAC_W-1:1];
  // position and latched step registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_q  <= '0;
      step_q <= '0;
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
    end
endmodule

// File: rtl/linear_scaler_ctrl.sv
// linear_scaler_ctrl: one-line horizontal scaler sequencer (centre alignment via LINEAR_SCALER_CTRL_CENTER_EN)
module linear_scaler_ctrl
  import scaler_pkg::*;
(
  input logic clk,
  input logic rst_n,
  linear_scaler_ctrl_if.slave io
);
  scaler_ctrl_state_t state_q, state_d;
  logic [LINE_W-1:0] in_w_q, in_w_d, out_w_q, out_w_d, in_idx_q, in_idx_d;
  logic [LINE_W-1:0] acc_q, acc_d, out_cnt_q, out_cnt_d;
  logic [PIXEL_WIDTH-1:0] p0_q, p0_d, p1_q, p1_d, pix0_q, pix0_d, pix1_q, pix1_d;
  logic have0_q, have0_d, valid_q, valid_d, eol_q, eol_d;
  logic init, issue, di_ready, more, last;
  logic [LINE_W-1:0] pos_int;
  logic [DX_W-1:0] pos_frac;

  scaler_pos_acc u_pos (
    .clk(clk), .rst_n(rst_n), .init_i(init), .adv_i(issue), .step_i(io.scale_step),
    .pos_int_o(pos_int), .pos_frac_o(pos_frac)
  );

  assign more        = acc_q < in_w_q;
  assign last        = out_cnt_q == out_w_q - 1'b1;
  assign io.busy     = state_q != IDLE;
  assign io.di_ready = di_ready;
  assign io.dx_en    = issue;
  assign io.dx       = pos_frac;
  assign io.do_pix0  = pix0_q;
  assign io.do_pix1  = pix1_q;
  assign io.do_valid = valid_q;
  assign io.do_eol   = eol_q;

  // next state: prime the window, then shift (priority) or issue one pair per cycle, then drain input
  always_comb begin
    state_d   = state_q;
    in_w_d    = in_w_q;
    out_w_d   = out_w_q;
    in_idx_d  = in_idx_q;
    acc_d     = acc_q;
    out_cnt_d = out_cnt_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    have0_d   = have0_q;
    pix0_d    = pix0_q;
    pix1_d    = pix1_q;
    valid_d   = valid_q & ~io.do_ready;
    eol_d     = eol_q & ~io.do_ready;
    init      = 1'b0;
    issue     = 1'b0;
    di_ready  = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        state_d   = PRIME;
        init      = 1'b1;
        in_w_d    = io.in_width;
        out_w_d   = io.out_width;
        in_idx_d  = '0;
        acc_d     = '0;
        out_cnt_d = '0;
        have0_d   = 1'b0;
      end
      PRIME: begin
        di_ready = 1'b1;
        in_idx_d = '0;
        if (io.di_valid) begin
          acc_d   = acc_q + 1'b1;
          have0_d = 1'b1;
          p1_d    = io.di_pix;
          p0_d    = have0_q ? p0_q : io.di_pix;
          state_d = (have0_q || in_w_q == LINE_W'(1)) ? RUN : PRIME;
        end
      end
      RUN: if (pos_int > in_idx_q) begin
        di_ready = more;
        if (!more || io.di_valid) begin
          p0_d     = p1_q;
          in_idx_d = in_idx_q + 1'b1;
          p1_d     = more ? io.di_pix : p1_q;
          acc_d    = more ? acc_q + 1'b1 : acc_q;
        end
      end else if (!valid_q || io.do_ready) begin
        issue     = 1'b1;
        pix0_d    = p0_q;
        pix1_d    = p1_q;
        valid_d   = 1'b1;
        eol_d     = last;
        out_cnt_d = out_cnt_q + 1'b1;
        state_d   = last ? DRAIN : RUN;
      end
      DRAIN: begin
        di_ready = more;
        acc_d    = (more && io.di_valid) ? acc_q + 1'b1 : acc_q;
        state_d  = more ? DRAIN : IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      in_w_q    <= '0;
      out_w_q   <= '0;
      in_idx_q  <= '0;
      acc_q     <= '0;
      out_cnt_q <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      have0_q   <= 1'b0;
      pix0_q    <= '0;
      pix1_q    <= '0;
      valid_q   <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_w_q    <= in_w_d;
      out_w_q   <= out_w_d;
      in_idx_q  <= in_idx_d;
      acc_q     <= acc_d;
      out_cnt_q <= out_cnt_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      have0_q   <= have0_d;
      pix0_q    <= pix0_d;
      pix1_q    <= pix1_d;
      valid_q   <= valid_d;
      eol_q     <= eol_d;
    end
endmodule

// File: tb/tb_linear_scaler_ctrl.sv
// tb_linear_scaler_ctrl: scoreboard bench for the linear scaler sequencer
module tb_linear_scaler_ctrl;
  import scaler_pkg::*;
  typedef struct packed {
    logic [7:0]      p0;
    logic [7:0]      p1;
    logic [DX_W-1:0] dx;
    logic            eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linear_scaler_ctrl_if bus();
  linear_scaler_ctrl dut (.clk(clk), .rst_n(rst_n), .io(bus));

  exp_t exp_q[$];
  logic [DX_W-1:0] dx_q[$];
  int checks = 0;
  int passes = 0;
  logic [7:0] pix[16];
  int n_in = 0, in_ptr = 0, acc_cnt = 0, out_cnt = 0, cyc = 0;
  int starve_at = -1, starve_left = 0;
  bit bp = 1'b0;
  bit [3:0] bp_pat = 4'b1001;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // input source and do_ready driver
  initial begin
    bit tk;
    forever begin
      @(negedge clk);
      tk = bus.di_valid & bus.di_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (tk) begin
        in_ptr++;
        acc_cnt++;
      end
      if (in_ptr == starve_at && starve_left > 0) begin
        bus.di_valid = 1'b0;
        starve_left--;
      end else bus.di_valid = in_ptr < n_in;
      bus.di_pix   = pix[in_ptr < 16 ? in_ptr : 15];
      bus.do_ready = bp ? bp_pat[cyc % 4] : 1'b1;
    end
  end

  // monitor: records issued ROM indices, checks held pairs and scoreboard on each accepted pair
  initial begin
    bit stall_prev = 1'b0;
    logic [16:0] hold = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          check("hold_pair", {bus.do_pix0, bus.do_pix1, bus.do_eol}, hold);
          check("hold_valid", bus.do_valid, 1);
        end
        stall_prev = bus.do_valid & ~bus.do_ready;
        hold = {bus.do_pix0, bus.do_pix1, bus.do_eol};
        if (bus.dx_en) begin
          dx_q.push_back(bus.dx);
          check("dx_en_while_stalled", bus.do_valid & ~bus.do_ready, 0);
        end
        if (bus.do_valid & bus.do_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: pair %0d,%0d with empty scoreboard", bus.do_pix0, bus.do_pix1);
          end else begin
            e = exp_q.pop_front();
            check("pix0", bus.do_pix0, e.p0);
            check("pix1", bus.do_pix1, e.p1);
            check("eol", bus.do_eol, e.eol);
            if (dx_q.size() == 0) begin
              checks++;
              $display("FAIL dx_missing: no dx_en before output, expected dx %0d", e.dx);
            end else check("dx", dx_q.pop_front(), e.dx);
          end
        end
      end
    end
  end

  task automatic push(input int a, input int b, input int d, input bit l);
    exp_t e;
    e.p0 = 8'(a); e.p1 = 8'(b); e.dx = DX_W'(d); e.eol = l;
    exp_q.push_back(e);
  endtask

  task automatic load_up();
    pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
    push(10, 20, 0, 0); push(10, 20, 1024, 0);
    push(20, 30, 0, 0); push(20, 30, 1024, 0);
    push(30, 40, 0, 0); push(30, 40, 1024, 0);
    push(40, 40, 0, 0); push(40, 40, 1024, 1);
  endtask

  task automatic load_down();
    int d;
`ifdef LINEAR_SCALER_CTRL_CENTER_EN
    d = 1024;
`else
    d = 0;
`endif
    for (int i = 0; i < 8; i++) pix[i] = 8'(11 * (i + 1));
    push(11, 22, d, 0); push(33, 44, d, 0); push(55, 66, d, 0); push(77, 88, d, 1);
  endtask

  task automatic start_line(input int step, input int inw, input int outw, input bit b, input int sa, input bit lat);
    @(posedge clk);
    #2;
    bus.scale_step = 16'(step);
    bus.in_width   = 13'(inw);
    bus.out_width  = 13'(outw);
    n_in = inw; in_ptr = 0; acc_cnt = 0; out_cnt = 0;
    bp = b; starve_at = sa; starve_left = (sa >= 0) ? 5 : 0;
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    if (lat) begin
      check("busy_after_start", bus.busy, 1);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      check("first_dx_en_cycle3", bus.dx_en, 1);
      @(posedge clk);
      #2;
      check("first_do_valid_cycle4", bus.do_valid, 1);
    end
  endtask

  task automatic finish_line(input int inw, input int outw);
    for (int i = 0; i < 2000 && (bus.busy || exp_q.size() != 0); i++) @(posedge clk);
    #2;
    check("line_complete_in_budget", bus.busy || exp_q.size() != 0, 0);
    check("inputs_accepted", acc_cnt, inw);
    check("outputs_seen", out_cnt, outw);
    check("di_ready_idle", bus.di_ready, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_di_ready"}, bus.di_ready, 0);
    check({tag, "_dx_en"}, bus.dx_en, 0);
    check({tag, "_dx"}, bus.dx, 0);
    check({tag, "_do_pix0"}, bus.do_pix0, 0);
    check({tag, "_do_pix1"}, bus.do_pix1, 0);
    check({tag, "_do_valid"}, bus.do_valid, 0);
    check({tag, "_do_eol"}, bus.do_eol, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.scale_step = '0; bus.in_width = '0; bus.out_width = '0;
    bus.di_pix = '0; bus.di_valid = 1'b0; bus.do_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;
    load_up();
    start_line(2048, 4, 8, 1'b0, -1, 1'b1);
    finish_line(4, 8);
    load_down();
    start_line(8192, 8, 4, 1'b0, -1, 1'b0);
    finish_line(8, 4);
    load_up();
    start_line(2048, 4, 8, 1'b1, -1, 1'b0);
    finish_line(4, 8);
    load_down();
    start_line(8192, 8, 4, 1'b0, 4, 1'b0);
    finish_line(8, 4);
    load_up();
    start_line(2048, 4, 8, 1'b0, -1, 1'b0);
    for (int i = 0; i < 200 && out_cnt < 3; i++) @(posedge clk);
    check("reached_output3", out_cnt >= 3, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midline_reset");
    exp_q.delete();
    dx_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_up();
    start_line(2048, 4, 8, 1'b0, -1, 1'b1);
    finish_line(4, 8);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
